// File: rtl/jtkunio_pkg.sv
// Shared types for the Kunio graphics ROM arbiter:
// slot ids, sequencer states, default ROM bases and the rr picker.
package jtkunio_pkg;

  typedef enum logic [1:0] {
    SLOT_CHAR = 2'd0,
    SLOT_SCR  = 2'd1,
    SLOT_OBJ  = 2'd2
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic  hit;
    slot_e slot;
  } pick_t;

  localparam logic [21:0] DEF_CHAR_OFFSET = 22'h0;
  localparam logic [21:0] DEF_SCR_OFFSET  = 22'h4000;
  localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h24000;

  function automatic slot_e rr_next(slot_e s);
    slot_e n;
    unique case (s)
      SLOT_CHAR: n = SLOT_SCR;
      SLOT_SCR:  n = SLOT_OBJ;
      default:   n = SLOT_CHAR;
    endcase
    return n;
  endfunction

  // ptr is the highest-priority slot this round
  function automatic pick_t rr_pick(
    logic [2:0] miss,
    slot_e      ptr
  );
    pick_t p;
    slot_e s;
    p.hit  = 1'b0;
    p.slot = ptr;
    s      = ptr;
    for (int i = 0; i < 3; i++) begin
      if (!p.hit && miss[s]) begin
        p.hit  = 1'b1;
        p.slot = s;
      end
      s = rr_next(s);
    end
    return p;
  endfunction

endpackage

// File: rtl/jtkunio_gfx_slot.sv
// One cached ROM word per requester: tag, data and valid,
// with a combinational hit compare against the live address.
module jtkunio_gfx_slot
  import jtkunio_pkg::*;
#(
  parameter int AWIDTH = 14
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic [AWIDTH-1:0] addr,
  input  logic              we,
  input  logic [AWIDTH-1:0] wtag,
  input  logic [31:0]       wdata,
  output logic [31:0]       data,
  output logic              ok,
  output logic              miss
);

  logic [AWIDTH-1:0] tag_q, tag_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              hit;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (we) begin
      tag_d   = wtag;
      data_d  = wdata;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign hit  = valid_q && (addr == tag_q);
  assign ok   = cs && hit;
  assign miss = cs && !hit;
  assign data = data_q;

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// Shares one SDRAM read port among char, scroll and object
// fetchers: three cached words and a round-robin miss sequencer.
module jtkunio_gfx_arb
  import jtkunio_pkg::*;
#(
  parameter int          AW          = 22,
  parameter logic [AW-1:0] CHAR_OFFSET = AW'(DEF_CHAR_OFFSET),
  parameter logic [AW-1:0] SCR_OFFSET  = AW'(DEF_SCR_OFFSET),
  parameter logic [AW-1:0] OBJ_OFFSET  = AW'(DEF_OBJ_OFFSET),
  parameter int          TIMEOUT     = 63
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          char_cs,
  input  logic [13:0]   char_addr,
  output logic [31:0]   char_data,
  output logic          char_ok,
  input  logic          scr_cs,
  input  logic [16:0]   scr_addr,
  output logic [31:0]   scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [17:0]   obj_addr,
  output logic [31:0]   obj_data,
  output logic          obj_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_rd,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [31:0]   sdram_dout
);

  state_e        state_q, state_d;
  slot_e         gnt_q, gnt_d;
  slot_e         ptr_q, ptr_d;
  logic [17:0]   fa_q, fa_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic [5:0]    timer_q, timer_d;

  logic          char_miss, scr_miss, obj_miss;
  logic [2:0]    miss;
  pick_t         pick;
  logic [17:0]   sel_addr;
  logic [AW-1:0] sel_off;
  logic          fill;

  assign miss = {obj_miss, scr_miss, char_miss};
  assign pick = rr_pick(miss, ptr_q);

  // ack and dst in the same REQ cycle count as a complete fetch
  assign fill = sdram_dst &&
                ((state_q == ST_WAIT) ||
                 (state_q == ST_REQ && sdram_ack));

  jtkunio_gfx_slot #(.AWIDTH(14)) u_char (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (char_cs),
    .addr  (char_addr),
    .we    (fill && gnt_q == SLOT_CHAR),
    .wtag  (fa_q[13:0]),
    .wdata (sdram_dout),
    .data  (char_data),
    .ok    (char_ok),
    .miss  (char_miss)
  );

  jtkunio_gfx_slot #(.AWIDTH(17)) u_scr (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (scr_cs),
    .addr  (scr_addr),
    .we    (fill && gnt_q == SLOT_SCR),
    .wtag  (fa_q[16:0]),
    .wdata (sdram_dout),
    .data  (scr_data),
    .ok    (scr_ok),
    .miss  (scr_miss)
  );

  jtkunio_gfx_slot #(.AWIDTH(18)) u_obj (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (obj_cs),
    .addr  (obj_addr),
    .we    (fill && gnt_q == SLOT_OBJ),
    .wtag  (fa_q),
    .wdata (sdram_dout),
    .data  (obj_data),
    .ok    (obj_ok),
    .miss  (obj_miss)
  );

  always_comb begin
    sel_addr = 18'(char_addr);
    sel_off  = CHAR_OFFSET;
    unique case (1'b1)
      pick.slot == SLOT_SCR: begin
        sel_addr = 18'(scr_addr);
        sel_off  = SCR_OFFSET;
      end
      pick.slot == SLOT_OBJ: begin
        sel_addr = obj_addr;
        sel_off  = OBJ_OFFSET;
      end
      default: begin
        sel_addr = 18'(char_addr);
        sel_off  = CHAR_OFFSET;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    fa_d    = fa_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick.hit) begin
          gnt_d   = pick.slot;
          ptr_d   = rr_next(pick.slot);
          fa_d    = sel_addr;
          addr_d  = AW'(sel_addr) + sel_off;
          rd_d    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          rd_d    = 1'b0;
          timer_d = '0;
          state_d = sdram_dst ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_dst) begin
          state_d = ST_IDLE;
        end else if (timer_q == 6'(TIMEOUT)) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= SLOT_CHAR;
      ptr_q   <= SLOT_CHAR;
      fa_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      fa_q    <= fa_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      timer_q <= timer_d;
    end
  end

  assign sdram_addr = addr_q;
  assign sdram_rd   = rd_q;

endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// Directed bench for jtkunio_gfx_arb: a hand-driven SDRAM
// responder and fixed expected addresses/data.
module tb_jtkunio_gfx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_cs = 1'b0;
  logic [13:0] char_addr = '0;
  logic [31:0] char_data;
  logic        char_ok;
  logic        scr_cs = 1'b0;
  logic [16:0] scr_addr = '0;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs = 1'b0;
  logic [17:0] obj_addr = '0;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_rd;
  logic        sdram_ack = 1'b0;
  logic        sdram_dst = 1'b0;
  logic [31:0] sdram_dout = '0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtkunio_gfx_arb u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_cs    (char_cs),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .char_ok    (char_ok),
    .scr_cs     (scr_cs),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_addr (sdram_addr),
    .sdram_rd   (sdram_rd),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_dout (sdram_dout)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wait for a read, check its address, then ack after ack_dly
  task automatic issue(
    input string       tag,
    input logic [21:0] exp_a,
    input int          ack_dly
  );
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sdram_rd && n < 20);
    chk({tag, "_rd"}, 64'(sdram_rd), 64'd1);
    chk({tag, "_addr"}, 64'(sdram_addr), 64'(exp_a));
    repeat (ack_dly) @(posedge clk);
    #1 sdram_ack = 1'b1;
    @(posedge clk);
    #1 sdram_ack = 1'b0;
  endtask

  task automatic land(input logic [31:0] d, input int dly);
    repeat (dly - 1) @(posedge clk);
    #1;
    sdram_dst  = 1'b1;
    sdram_dout = d;
    @(posedge clk);
    #1;
    sdram_dst  = 1'b0;
    sdram_dout = '0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int  cnt;
    bit  okseen;

    // reset with every requester active on random addresses
    char_cs   = 1'b1;
    scr_cs    = 1'b1;
    obj_cs    = 1'b1;
    char_addr = 14'($urandom);
    scr_addr  = 17'($urandom);
    obj_addr  = 18'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_char_ok", 64'(char_ok), 64'd0);
    chk("rst_scr_ok", 64'(scr_ok), 64'd0);
    chk("rst_obj_ok", 64'(obj_ok), 64'd0);
    chk("rst_rd", 64'(sdram_rd), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_data", 64'(char_data), 64'd0);
    char_cs = 1'b0;
    scr_cs  = 1'b0;
    obj_cs  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("nocs_rd", 64'(sdram_rd), 64'd0);

    // single char miss
    @(posedge clk);
    #1;
    char_cs   = 1'b1;
    char_addr = 14'h0123;
    issue("t2", 22'h000123, 2);
    @(negedge clk);
    chk("t2_ok_pre", 64'(char_ok), 64'd0);
    land(32'hDEADBEEF, 5);
    @(negedge clk);
    chk("t2_ok", 64'(char_ok), 64'd1);
    chk("t2_data", 64'(char_data), 64'hDEADBEEF);

    // round robin with all three missing
    do_reset();
    char_cs   = 1'b1;
    scr_cs    = 1'b1;
    obj_cs    = 1'b1;
    char_addr = 14'h0200;
    scr_addr  = 17'h00020;
    obj_addr  = 18'h00010;
    issue("rr_c", 22'h000200, 1);
    land(32'hC0C0C0C0, 2);
    issue("rr_s", 22'h004020, 1);
    land(32'h5C5C5C5C, 2);
    issue("rr_o", 22'h024010, 1);
    land(32'h0B0B0B0B, 2);
    @(negedge clk);
    chk("rr_char_ok", 64'(char_ok), 64'd1);
    chk("rr_scr_ok", 64'(scr_ok), 64'd1);
    chk("rr_obj_ok", 64'(obj_ok), 64'd1);
    chk("rr_obj_data", 64'(obj_data), 64'h0B0B0B0B);
    chk("rr_scr_data", 64'(scr_data), 64'h5C5C5C5C);

    // timeout: ack without dst, then re-issue
    @(posedge clk);
    #1 obj_addr = 18'h00100;
    issue("to", 22'h024100, 1);
    cnt    = 0;
    okseen = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (obj_ok) okseen = 1'b1;
    end while (!sdram_rd && cnt < 100);
    chk("to_cycles", 64'(cnt), 64'd66);
    chk("to_ok_low", 64'(okseen), 64'd0);
    issue("to_re", 22'h024100, 1);
    land(32'h12345678, 3);
    @(negedge clk);
    chk("to_ok", 64'(obj_ok), 64'd1);
    chk("to_data", 64'(obj_data), 64'h12345678);

    // scroll address change while the fetch is in WAIT
    @(posedge clk);
    #1;
    char_cs  = 1'b0;
    obj_cs   = 1'b0;
    scr_addr = 17'h00010;
    issue("t4a", 22'h004010, 1);
    scr_addr = 17'h00011;
    land(32'h11112222, 3);
    @(negedge clk);
    chk("t4_stale_ok", 64'(scr_ok), 64'd0);
    issue("t4b", 22'h004011, 1);
    land(32'h33334444, 2);
    @(negedge clk);
    chk("t4_ok", 64'(scr_ok), 64'd1);
    chk("t4_data", 64'(scr_data), 64'h33334444);

    // ack and dst in the same cycle, top scroll address
    @(posedge clk);
    #1 scr_addr = 17'h1FFFF;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sdram_rd && cnt < 20);
    chk("sc_addr", 64'(sdram_addr), 64'h023FFF);
    @(posedge clk);
    #1;
    sdram_ack  = 1'b1;
    sdram_dst  = 1'b1;
    sdram_dout = 32'h5A5A0FF0;
    @(posedge clk);
    #1;
    sdram_ack  = 1'b0;
    sdram_dst  = 1'b0;
    sdram_dout = '0;
    @(negedge clk);
    chk("sc_ok", 64'(scr_ok), 64'd1);
    chk("sc_data", 64'(scr_data), 64'h5A5A0FF0);
    chk("sc_rd", 64'(sdram_rd), 64'd0);

    // async reset mid-WAIT, late dst lands in IDLE
    @(posedge clk);
    #1;
    scr_cs    = 1'b0;
    char_cs   = 1'b1;
    char_addr = 14'h0321;
    issue("t6", 22'h000321, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #3;
    rst_n      = 1'b1;
    sdram_dst  = 1'b1;
    sdram_dout = 32'hBADBAD00;
    @(negedge clk);
    chk("t6_rst_rd", 64'(sdram_rd), 64'd0);
    chk("t6_rst_ok", 64'(char_ok), 64'd0);
    @(posedge clk);
    #1;
    sdram_dst  = 1'b0;
    sdram_dout = '0;
    @(negedge clk);
    chk("t6_late_ok", 64'(char_ok), 64'd0);
    chk("t6_rereq", 64'(sdram_rd), 64'd1);
    chk("t6_readdr", 64'(sdram_addr), 64'h000321);
    issue("t6b", 22'h000321, 1);
    land(32'h0BADF00D, 2);
    @(negedge clk);
    chk("t6_ok", 64'(char_ok), 64'd1);
    chk("t6_data", 64'(char_data), 64'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
